data_memory_subword: RTL and testbench

Parametrised MIPS data memory: successor to the fixed word-only data memory. Adds byte/halfword/word access with sign or zero extension, a registered read port, misalignment detection and an optional zero-fill sweep after reset. Sits in the MEM stage between the ALU result (address) and the write-back mux (readData).

---
 rtl/data_memory_subword_if.sv | 40 ++++
 rtl/data_memory_subword.sv | 160 ++++++++++++++++
 tb/tb_data_memory_subword.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_memory_subword_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_subword_if
// Description : Request/response bundle between the MEM stage and the
//               sub-word data memory. The master drives address, store data
//               and request qualifiers. The slave returns the registered load
//               result, the misalignment flag and ready.
//   address      byte address (word select + lane select, upper bits wrap)
//   writeData    right-justified store data
//   MemRead      load request
//   MemWrite     store request
//   size         00 byte, 01 half, 10 word, 11 reserved
//   unsignedLoad 1 = zero-extend sub-word loads, 0 = sign-extend
//   readData     registered load result
//   misaligned   registered error flag for the previous accepted request
//   ready        memory is accepting requests
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_subword_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        unsignedLoad;
    logic [31:0] readData;
    logic        misaligned;
    logic        ready;

    modport master (
        output address, writeData, MemRead, MemWrite, size, unsignedLoad,
        input  readData, misaligned, ready
    );

    modport slave (
        input  address, writeData, MemRead, MemWrite, size, unsignedLoad,
        output readData, misaligned, ready
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_subword.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_subword
// Description : MIPS data memory with byte/half/word access, sign or zero
//               extension on loads, a registered read port, misalignment
//               detection and an optional zero-fill sweep after reset.
// Ports       : clk   - sole clock, rising edge
//               reset - synchronous, active-high
//               bus   - data_memory_subword_if.slave. It carries the
//                       request (address, writeData, MemRead, MemWrite, size,
//                       unsignedLoad) and the response (readData, misaligned,
//                       ready).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_subword #(
    parameter int ADDR_BITS      = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    data_memory_subword_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   cnt_q;
    logic                   ready_q;
    logic [31:0]            rdata_q, rdata_d;
    logic                   mis_q, mis_d;
    logic [31:0]            mem_q [DEPTH];

    logic [ADDR_BITS-1:0]   w_idx;
    logic [1:0]             w_lane;
    logic                   w_mis;
    logic                   w_accept;
    logic                   w_store;
    logic [3:0]             w_be;
    logic [31:0]            w_wdata;
    logic [31:0]            w_word;
    logic [7:0]             w_byte;
    logic [15:0]            w_half;
    logic [31:0]            w_load;
    // Upper address bits intentionally wrap; folded here so they are consumed.
    logic                   w_unused_addr;

    assign w_idx         = bus.address[ADDR_BITS+1:2];
    assign w_lane        = bus.address[1:0];
    assign w_unused_addr = ^bus.address[31:ADDR_BITS+2];

    assign w_mis = (bus.size == 2'b11)
                 | ((bus.size == 2'b01) & bus.address[0])
                 | ((bus.size == 2'b10) & (w_lane != 2'b00));

    // ready_q is only high in RUN, so it alone qualifies acceptance.
    assign w_accept = ready_q & (bus.MemRead | bus.MemWrite);
    assign w_store  = w_accept & bus.MemWrite & ~w_mis & ~reset;

    // Replicate the right-justified store data across the lanes so that the
    // byte enables alone pick which lanes change.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.writeData;
        case (bus.size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.writeData[7:0]}};
            end
            2'b01: begin
                w_be    = bus.address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.writeData[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = bus.writeData;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = bus.writeData;
            end
        endcase
    end

    // Load path reads the pre-edge contents, which yields read-before-write
    // when a load and a store hit the same word in one cycle.
    assign w_word = mem_q[w_idx];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = bus.address[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (bus.size)
            2'b00:   w_load = bus.unsignedLoad ? {24'h0, w_byte}
                                               : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = bus.unsignedLoad ? {16'h0, w_half}
                                               : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Response next-state: updated only for accepted requests in RUN.
    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (state_q == ST_RUN) begin
            mis_d = w_accept & w_mis;
            if (w_accept && bus.MemRead) begin
                rdata_d = w_mis ? 32'h0 : w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            ready_q <= ~CLEAR_ON_RESET;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_BITS{1'b1}}) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage array carries no reset; the sweep clears it when enabled.
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_INIT) begin
            mem_q[cnt_q] <= 32'h0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.readData   = rdata_q;
    assign bus.misaligned = mis_q;
    assign bus.ready      = ready_q;
endmodule
`default_nettype wire

// File: tb/tb_data_memory_subword.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_subword
// Description : Directed bench for data_memory_subword. Expected load
//               results are queued when a load is driven and popped when the
//               registered response appears one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_subword;
    logic clk;
    logic reset;

    data_memory_subword_if bus ();

    data_memory_subword #(
        .ADDR_BITS      (8),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.size         = 2'b10;
        bus.unsignedLoad = 1'b0;
        bus.address      = 32'h0;
        bus.writeData    = 32'h0;
    endtask

    // Drive one request, advance one edge, sample 1 time unit after it.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
        bus.MemRead      = rd;
        bus.MemWrite     = wr;
        bus.size         = sz;
        bus.unsignedLoad = uns;
        bus.address      = a;
        bus.writeData    = wd;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        op(1'b0, 1'b1, sz, 1'b0, a, wd);
    endtask

    // Load (optionally combined with a store) checked through the scoreboard.
    task automatic ld(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_data, input logic exp_mis);
        exp_t e;
        exp_t g;
        e.tag  = tag;
        e.data = exp_data;
        e.mis  = exp_mis;
        sb_q.push_back(e);
        op(1'b1, wr, sz, uns, a, wd);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            g = sb_q.pop_front();
            chk({g.tag, ".data"}, bus.readData, g.data);
            chk({g.tag, ".mis"}, {31'h0, bus.misaligned}, {31'h0, g.mis});
        end
    endtask

    // Apply reset for n cycles, then count cycles until ready rises.
    // A store to word 0 is attempted midway through the sweep.
    task automatic reset_and_sweep(input int n, input string tag);
        int cyc;
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        chk({tag, ".rst_rdata"}, bus.readData, 32'h0);
        chk({tag, ".rst_mis"}, {31'h0, bus.misaligned}, 32'h0);
        chk({tag, ".rst_ready"}, {31'h0, bus.ready}, 32'h0);
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 400) begin
            if (cyc == 10) begin
                op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678);
            end else begin
                op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
            end
            cyc++;
        end
        chk({tag, ".sweep_cycles"}, cyc, 32'd256);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Power-on sweep; the store issued during INIT must be dropped.
        reset_and_sweep(2, "por");
        ld("init_ignore_lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Preload word 5, reset once, sweep must clear it.
        st(2'b10, 32'h14, 32'hDEAD_BEEF);
        ld("preload_lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0);
        reset_and_sweep(1, "rst2");
        ld("swept_lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0);

        // Sub-word stores and loads.
        st(2'b10, 32'h20, 32'h1122_3344);
        st(2'b00, 32'h21, 32'h0000_00AA);
        ld("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122_AA44, 1'b0);
        ld("lb21",  1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFF_FFAA, 1'b0);
        ld("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_00AA, 1'b0);
        ld("lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_1122, 1'b0);
        ld("lb20",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0000_0044, 1'b0);
        ld("lb23",  1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0011, 1'b0);
        ld("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_AA44, 1'b0);

        // Halfword sign/zero extension in the upper half.
        st(2'b01, 32'h32, 32'h0000_8001);
        ld("lh32",  1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF_8001, 1'b0);
        ld("lhu32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h0000_8001, 1'b0);
        ld("lw30",  1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h8001_0000, 1'b0);

        // Misaligned store: flag set, memory untouched, readData held.
        st(2'b10, 32'h40, 32'hCAFE_F00D);
        st(2'b10, 32'h41, 32'h0000_0055);
        chk("mis_sw41.flag", {31'h0, bus.misaligned}, 32'h1);
        chk("mis_sw41.rdata_held", bus.readData, 32'h8001_0000);
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        chk("idle.mis_clear", {31'h0, bus.misaligned}, 32'h0);
        chk("idle.rdata_held", bus.readData, 32'h8001_0000);
        ld("lw40_after_mis", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);
        ld("mis_lh43",       1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1);
        ld("lw40_again",     1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);
        ld("mis_size11",     1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        ld("mis_lw42",       1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1);
        ld("lw40_final",     1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);

        // Read-before-write on the same word.
        st(2'b10, 32'h50, 32'h0000_0001);
        ld("rbw_old", 1'b1, 2'b10, 1'b0, 32'h50, 32'h0000_0002, 32'h0000_0001, 1'b0);
        ld("rbw_new", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0,         32'h0000_0002, 1'b0);

        // Address wrap: 0x404 aliases byte address 0x4.
        st(2'b10, 32'h404, 32'h0000_0077);
        ld("wrap_lw4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0000_0077, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
